// File: rtl/msx_joyport_ctrl.sv
// MSX joystick-port arbiter sharing one PS/2 mouse with two joystick ports.
// Define MOUSE_AUTOSWITCH_EN for activity-driven attach/detach with an idle timeout.
module msx_joyport_ctrl #(
  parameter logic [23:0] TIMEOUT = 24'd10_700_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psg_portsel,
  input  logic [1:0] psg_strobe,
  input  logic [5:0] joy_a,
  input  logic [5:0] joy_b,
  input  logic       mouse_en,
  input  logic       mouse_port,
  input  logic       mouse_toggle,
  input  logic [5:0] mouse_data,
  output logic       mouse_strobe,
  output logic [5:0] psg_data,
  output logic       mouse_active,
  output logic       mouse_owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ATT_A = 2'd1,
    ATT_B = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic       toggle_r;
  logic       act_evt_s;
  logic       next_att_s;
  logic       next_owner_s;
  logic       mouse_strobe_r;
  logic [5:0] psg_data_r;
  logic       mouse_active_r;
  logic       mouse_owner_r;

  // Toggle history; reset also loads the live value so no event fires right after reset.
  always_ff @(posedge clk) begin
    toggle_r <= mouse_toggle;
  end

  assign act_evt_s = toggle_r ^ mouse_toggle;

`ifdef MOUSE_AUTOSWITCH_EN
  logic [23:0] timer_r;
  logic [23:0] timer_s;
  logic        watch_port_s;
  logic        joy_act_s;
  logic        timeout_s;

  // In IDLE watch the port the mouse would take, so a busy joystick blocks attach.
  assign watch_port_s = (state_r == IDLE) ? mouse_port : (state_r == ATT_B);
  assign joy_act_s    = (watch_port_s ? joy_b : joy_a) != 6'h3F;
  assign timeout_s    = !act_evt_s && (timer_r >= (TIMEOUT - 24'd1));

  // Next-state decode for activity-driven ownership.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mouse_en && act_evt_s && !joy_act_s) begin
          state_s = mouse_port ? ATT_B : ATT_A;
        end else begin
          state_s = IDLE;
        end
      end
      ATT_A, ATT_B: begin
        if (joy_act_s || !mouse_en || (mouse_port != (state_r == ATT_B)) || timeout_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Idle timer: cleared on entry and activity, saturating while attached.
  always_comb begin
    timer_s = timer_r;
    if ((state_r == IDLE) || (state_s == IDLE) || act_evt_s) begin
      timer_s = 24'd0;
    end else if (timer_r < TIMEOUT) begin
      timer_s = timer_r + 24'd1;
    end else begin
      timer_s = timer_r;
    end
  end

  // Idle timer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= 24'd0;
    end else begin
      timer_r <= timer_s;
    end
  end
`else
  logic unused_s;

  assign unused_s = ^{act_evt_s, TIMEOUT};

  // Next-state decode: ownership follows mouse_en, a port change passes through IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mouse_en) begin
          state_s = mouse_port ? ATT_B : ATT_A;
        end else begin
          state_s = IDLE;
        end
      end
      ATT_A, ATT_B: begin
        if (!mouse_en || (mouse_port != (state_r == ATT_B))) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = IDLE;
    endcase
  end
`endif

  assign next_att_s   = (state_s != IDLE);
  assign next_owner_s = (state_s == ATT_B);

  // State and output registers, all derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      mouse_active_r <= 1'b0;
      mouse_owner_r  <= 1'b0;
      mouse_strobe_r <= 1'b0;
      psg_data_r     <= 6'h3F;
    end else begin
      state_r        <= state_s;
      mouse_active_r <= next_att_s;
      mouse_owner_r  <= next_owner_s;
      mouse_strobe_r <= next_att_s ? psg_strobe[next_owner_s] : 1'b0;
      if (next_att_s && (psg_portsel == next_owner_s)) begin
        psg_data_r <= mouse_data;
      end else begin
        psg_data_r <= psg_portsel ? joy_b : joy_a;
      end
    end
  end

  assign mouse_strobe = mouse_strobe_r;
  assign psg_data     = psg_data_r;
  assign mouse_active = mouse_active_r;
  assign mouse_owner  = mouse_owner_r;

endmodule

// File: tb/tb_msx_joyport_ctrl.sv
// Directed-vector bench for msx_joyport_ctrl; covers either MOUSE_AUTOSWITCH_EN build.
module tb_msx_joyport_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       psg_portsel;
  logic [1:0] psg_strobe;
  logic [5:0] joy_a;
  logic [5:0] joy_b;
  logic       mouse_en;
  logic       mouse_port;
  logic       mouse_toggle;
  logic [5:0] mouse_data;
  logic       mouse_strobe;
  logic [5:0] psg_data;
  logic       mouse_active;
  logic       mouse_owner;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       port;
    logic       sel;
    logic [1:0] strb;
    logic [5:0] ja;
    logic [5:0] jb;
    logic [5:0] md;
    logic       tog;
    logic       e_act;
    logic       e_own;
    logic       e_strb;
    logic [5:0] e_pd;
  } vec_t;

  vec_t vecs[$];

  msx_joyport_ctrl #(.TIMEOUT(24'd16)) dut (
    .clk          (clk),
    .reset        (reset),
    .psg_portsel  (psg_portsel),
    .psg_strobe   (psg_strobe),
    .joy_a        (joy_a),
    .joy_b        (joy_b),
    .mouse_en     (mouse_en),
    .mouse_port   (mouse_port),
    .mouse_toggle (mouse_toggle),
    .mouse_data   (mouse_data),
    .mouse_strobe (mouse_strobe),
    .psg_data     (psg_data),
    .mouse_active (mouse_active),
    .mouse_owner  (mouse_owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset        = v.rst;
    mouse_en     = v.en;
    mouse_port   = v.port;
    psg_portsel  = v.sel;
    psg_strobe   = v.strb;
    joy_a        = v.ja;
    joy_b        = v.jb;
    mouse_data   = v.md;
    mouse_toggle = v.tog;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                rst   en    port  sel   strb   ja     jb     md     tog   act   own   strb  pd
`ifdef MOUSE_AUTOSWITCH_EN
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 6'h3F, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 6'h3F, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 6'h3F, 6'h3F, 6'h2A, 1'b1, 1'b1, 1'b1, 1'b1, 6'h2A});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 6'h3F, 6'h3E, 6'h2A, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3E});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 6'h3F, 6'h3E, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3E});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 6'h3F, 6'h3F, 6'h11, 1'b1, 1'b1, 1'b0, 1'b1, 6'h11});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 6'h3F, 6'h3D, 6'h11, 1'b1, 1'b1, 1'b0, 1'b0, 6'h3D});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 6'h3B, 6'h3F, 6'h11, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3B});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 6'h3F, 6'h3F, 6'h11, 1'b1, 1'b1, 1'b0, 1'b0, 6'h11});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 6'h3F, 6'h3F, 6'h11, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3F});
`else
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 6'h3F, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 6'h3E, 6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3E});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 6'h3F, 6'h3F, 6'h15, 1'b0, 1'b1, 1'b0, 1'b1, 6'h15});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 6'h3F, 6'h3D, 6'h15, 1'b0, 1'b1, 1'b0, 1'b0, 6'h3D});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 6'h3E, 6'h3F, 6'h2A, 1'b0, 1'b1, 1'b0, 1'b1, 6'h2A});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 6'h3F, 6'h3F, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 6'h3F, 6'h3F, 6'h0A, 1'b0, 1'b1, 1'b1, 1'b1, 6'h0A});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 6'h3B, 6'h3F, 6'h0A, 1'b1, 1'b1, 1'b1, 1'b0, 6'h3B});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 6'h3F, 6'h3C, 6'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 6'h3C});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 6'h3F, 6'h3F, 6'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 6'h3F, 6'h3F, 6'h07, 1'b0, 1'b1, 1'b0, 1'b1, 6'h07});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 6'h3F, 6'h3F, 6'h07, 1'b0, 1'b0, 1'b0, 1'b0, 6'h3F});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 6'h3F, 6'h3F, 6'h07, 1'b0, 1'b1, 1'b0, 1'b1, 6'h07});
`endif

    @(negedge clk);
    foreach (vecs[i]) begin
      apply(vecs[i]);
      check("mouse_active", i, {5'd0, mouse_active}, {5'd0, vecs[i].e_act});
      check("mouse_owner", i, {5'd0, mouse_owner}, {5'd0, vecs[i].e_own});
      check("mouse_strobe", i, {5'd0, mouse_strobe}, {5'd0, vecs[i].e_strb});
      check("psg_data", i, psg_data, vecs[i].e_pd);
    end

    reset = 1'b0;
`ifdef MOUSE_AUTOSWITCH_EN
    // Idle timeout: attach, then active must last exactly 16 edges.
    mouse_en = 1'b1; mouse_port = 1'b0; joy_a = 6'h3F; joy_b = 6'h3F;
    mouse_toggle = ~mouse_toggle;
    step();
    check("timer_attach", 0, {5'd0, mouse_active}, 6'd1);
    for (int k = 1; k <= 16; k++) begin
      step();
      check("timer_run", k, {5'd0, mouse_active}, (k < 16) ? 6'd1 : 6'd0);
    end
    // Restart: toggle before edge 15 pushes the drop to edge 31.
    mouse_toggle = ~mouse_toggle;
    step();
    check("restart_attach", 0, {5'd0, mouse_active}, 6'd1);
    for (int k = 1; k <= 31; k++) begin
      if (k == 15) mouse_toggle = ~mouse_toggle;
      step();
      check("restart_run", k, {5'd0, mouse_active}, (k < 31) ? 6'd1 : 6'd0);
    end
`else
    // Activity, joystick and time never detach in this build.
    mouse_en = 1'b1; mouse_port = 1'b0; psg_portsel = 1'b0; mouse_data = 6'h19;
    for (int k = 0; k < 40; k++) begin
      mouse_toggle = ~mouse_toggle;
      joy_a = 6'($urandom_range(0, 62));
      step();
      check("hold_active", k, {5'd0, mouse_active}, 6'd1);
      check("hold_data", k, psg_data, 6'h19);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msx_joyport_ctrl.md
MSX_JOYPORT_CTRL -- requirements
Module: msx_joyport_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 24'd10_700_000, giving the number of clk cycles without mouse activity before auto-detach.
REQ-002 SHALL have port clk, input, 1, the system clock.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port psg_portsel, input, 1, PSG R15 bit 6 (0 = port A read, 1 = port B read).
REQ-005 SHALL have port psg_strobe, input, 2, PSG R15 pin-8 outputs ([0] = port A, [1] = port B).
REQ-006 SHALL have port joy_a, input, 6, port A joystick, active-low {trigB, trigA, right, left, down, up}.
REQ-007 SHALL have port joy_b, input, 6, port B joystick, with the same encoding as joy_a.
REQ-008 SHALL have port mouse_en, input, 1, the user mouse enable.
REQ-009 SHALL have port mouse_port, input, 1, the port the mouse attaches to (0 = A, 1 = B).
REQ-010 SHALL have port mouse_toggle, input, 1, the PS/2 packet toggle; each level change is one mouse-activity event.
REQ-011 SHALL have port mouse_data, input, 6, the nibble and buttons returned by the mouse serializer.
REQ-012 SHALL have port mouse_strobe, output, 1, the strobe forwarded to the mouse serializer.
REQ-013 SHALL have port psg_data, output, 6, the data presented to PSG port A bits 5:0.
REQ-014 SHALL have port mouse_active, output, 1, high while the mouse is attached.
REQ-015 SHALL have port mouse_owner, output, 1, the port currently owned by the mouse (valid when mouse_active = 1).

Function
REQ-016 SHALL implement states IDLE, ATT_A and ATT_B; mouse_active = 1 in ATT_A/ATT_B; mouse_owner = 0 in ATT_A and 1 in ATT_B.
REQ-017 SHALL register mouse_toggle and flag an activity event when the registered value differs from the input.
REQ-018 SHALL flag joystick activity on the owned port when that port's joy input is not 6'h3F.
REQ-019 In IDLE, with mouse_en = 1 and an activity event, SHALL enter ATT_A or ATT_B per mouse_port on the next cycle.
REQ-020 In ATT_x, SHALL return to IDLE on any of: owned-port joystick activity; mouse_en = 0; mouse_port differing from the owner; timer reaching TIMEOUT.
REQ-021 SHALL give precedence to joystick activity when it coincides with a mouse event.
  - In IDLE with both present: stay IDLE.
  - In ATT_x with both present: detach.
REQ-022 The idle timer SHALL:
  - clear on entry to ATT_x and on each activity event;
  - increment once per cycle while attached;
  - saturate at TIMEOUT;
  - hold at 0 in IDLE.
REQ-023 A mouse_port change while attached SHALL pass through IDLE for at least one cycle, then re-attach only on a new activity event.
REQ-024 mouse_strobe SHALL be registered with 1-cycle latency:
  - psg_strobe[owner] when attached;
  - 0 in IDLE and in the cycle of detach.
REQ-025 psg_data SHALL be registered with 1-cycle latency:
  - mouse_data when attached and psg_portsel == owner;
  - otherwise joy_a when psg_portsel = 0, joy_b when psg_portsel = 1.
REQ-026 The joystick on the non-owned port SHALL always pass through unaffected.

Reset
REQ-027 On reset, SHALL set:
  - state = IDLE, timer = 0;
  - psg_data = 6'h3F;
  - mouse_strobe = 0, mouse_active = 0, mouse_owner = 0;
  - the mouse_toggle register = mouse_toggle, so no event is flagged on the first cycle after reset.
REQ-028 Reset asserted mid-attach SHALL detach within the same clock edge and override all other transitions.

Configuration
REQ-029 With MOUSE_AUTOSWITCH_EN defined, SHALL implement the activity-driven attach/detach of REQ-019 to REQ-023.
REQ-030 Without MOUSE_AUTOSWITCH_EN:
  - attach when mouse_en = 1, independent of activity, joystick input and timer;
  - detach when mouse_en = 0 or mouse_port changes, with one IDLE cycle;
  - remove the timer logic.

Verification
REQ-031 (macro defined) mouse_en = 1, mouse_port = 1, toggle flip -> mouse_active = 1 and mouse_owner = 1 after 1 cycle; psg_portsel = 1, mouse_data = 6'h2A -> psg_data = 6'h2A next cycle.
REQ-032 (macro defined) attached to port B, joy_b = 6'h3E -> IDLE next cycle, psg_data = 6'h3E, mouse_strobe = 0.
REQ-033 (macro defined) TIMEOUT = 16, attached, no activity -> mouse_active drops exactly 16 cycles after the last event; a toggle at cycle 15 restarts the count.
REQ-034 Attached to port A, psg_strobe = 2'b01 then 2'b10 -> mouse_strobe = 1 then 0, each one cycle later; with psg_portsel = 1 and joy_b = 6'h3D -> psg_data = 6'h3D.
REQ-035 (macro defined) toggle flip and joy_a = 6'h3B in the same cycle while attached to A -> detach; reset during ATT_A -> psg_data = 6'h3F and mouse_active = 0 next cycle.
REQ-036 (macro undefined) mouse_en = 1 -> attached next cycle with no toggle; mouse_port 0 -> 1 -> one cycle with mouse_active = 0, then mouse_owner = 1.
